// File: rtl/pipelined_adder_tree.sv
// Pipelined binary adder tree (one register per level) with optional tagged running accumulator.
// Latency log2(N_IN) cycles to out_sum, +1 to acc_sum; no backpressure, one sample per cycle.
module pipelined_adder_tree #(
  parameter int N_IN   = 8,
  parameter int DATA_W = 8,
  parameter int SIGNED = 0,
  parameter int ACC_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_IN*DATA_W-1:0]               in_data,
  input  logic                                 in_valid,
  input  logic                                 in_acc,
  input  logic                                 acc_clr,
  output logic [DATA_W+$clog2(N_IN)-1:0]       out_sum,
  output logic                                 out_valid,
  output logic [ACC_W-1:0]                     acc_sum,
  output logic                                 acc_valid
);

  localparam int LVL   = $clog2(N_IN);
  localparam int SUM_W = DATA_W + LVL;
  localparam bit SX    = (SIGNED != 0);

  genvar j, k;
  generate
    for (j = 0; j < LVL; j++) begin : g_lvl
      localparam int NN = N_IN >> (j + 1);
      localparam int IW = DATA_W + j;
      localparam int OW = IW + 1;

      logic [2*NN*IW-1:0] src;
      logic               src_vld;
      logic               src_acc;
      logic [NN*OW-1:0]   sum_d;
      logic [NN*OW-1:0]   sum_q;
      logic               vld_q;
      logic               acc_q;

      if (j == 0) begin : g_src
        assign src     = in_data;
        assign src_vld = in_valid;
        assign src_acc = in_acc;
      end else begin : g_src
        assign src     = g_lvl[j-1].sum_q;
        assign src_vld = g_lvl[j-1].vld_q;
        assign src_acc = g_lvl[j-1].acc_q;
      end

      // One extra bit per level is enough to make every addition exact.
      for (k = 0; k < NN; k++) begin : g_add
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        assign a = src[(2*k)*IW +: IW];
        assign b = src[(2*k+1)*IW +: IW];
        assign sum_d[k*OW +: OW] = {(SX ? a[IW-1] : 1'b0), a} + {(SX ? b[IW-1] : 1'b0), b};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
          vld_q <= 1'b0;
          acc_q <= 1'b0;
        end else begin
          vld_q <= src_vld;
          acc_q <= src_vld & src_acc;
          if (src_vld) begin
            sum_q <= sum_d;
          end
        end
      end
    end
  endgenerate

  logic             last_acc;
  logic [ACC_W-1:0] sum_ext;

  assign out_sum   = g_lvl[LVL-1].sum_q;
  assign out_valid = g_lvl[LVL-1].vld_q;
  assign last_acc  = g_lvl[LVL-1].acc_q;
  assign sum_ext   = SX ? ACC_W'(signed'(out_sum)) : ACC_W'(out_sum);

  // A clear coinciding with a tagged completion restarts the total from that sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sum   <= '0;
      acc_valid <= 1'b0;
    end else if (out_valid && last_acc) begin
      acc_sum   <= (acc_clr ? '0 : acc_sum) + sum_ext;
      acc_valid <= 1'b1;
    end else begin
      acc_valid <= 1'b0;
      if (acc_clr) begin
        acc_sum <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Scoreboard bench for pipelined_adder_tree: three instances (default, signed, 12-bit accumulator).
module tb_pipelined_adder_tree;

  typedef struct {
    int          inst;
    int          kind;   // 0 = out_sum, 1 = acc_sum
    int          due;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  logic [63:0] din [3];
  logic        vin [3];
  logic        ain [3];
  logic        cin [3];

  logic [15:0] osum [3];
  logic        oval [3];
  logic [15:0] asum [3];
  logic        aval [3];

  logic [10:0] os0, os1, os2;
  logic [15:0] as0, as1;
  logic [11:0] as2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_tree u_def (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(vin[0]), .in_acc(ain[0]), .acc_clr(cin[0]),
    .out_sum(os0), .out_valid(oval[0]), .acc_sum(as0), .acc_valid(aval[0]));

  pipelined_adder_tree #(.SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(vin[1]), .in_acc(ain[1]), .acc_clr(cin[1]),
    .out_sum(os1), .out_valid(oval[1]), .acc_sum(as1), .acc_valid(aval[1]));

  pipelined_adder_tree #(.ACC_W(12)) u_acc (
    .clk(clk), .rst(rst), .in_data(din[2]), .in_valid(vin[2]), .in_acc(ain[2]), .acc_clr(cin[2]),
    .out_sum(os2), .out_valid(oval[2]), .acc_sum(as2), .acc_valid(aval[2]));

  assign osum[0] = {5'b0, os0};
  assign osum[1] = {5'b0, os1};
  assign osum[2] = {5'b0, os2};
  assign asum[0] = as0;
  assign asum[1] = as1;
  assign asum[2] = {4'b0, as2};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the oldest pending expectation of this instance/kind and checks value and arrival cycle.
  task automatic match(input int inst, input int kind, input logic [15:0] act);
    int idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].inst == inst && sb[i].kind == kind) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected inst%0d kind%0d: got %h with nothing expected (cycle %0d)", inst, kind, act, cyc);
    end else begin
      if (act !== sb[idx].val || cyc != sb[idx].due) begin
        errors++;
        $display("FAIL inst%0d kind%0d: got %h at cycle %0d expected %h at cycle %0d",
                 inst, kind, act, cyc, sb[idx].val, sb[idx].due);
      end
      sb.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (oval[i] === 1'b1) match(i, 0, osum[i]);
      if (aval[i] === 1'b1) match(i, 1, asum[i]);
    end
  end

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; vin[i] = 1'b0; ain[i] = 1'b0; cin[i] = 1'b0;
    end
  endtask

  task automatic drive(input int inst, input logic [63:0] d, input logic v, input logic a,
                       input logic c, input logic r = 1'b0);
    @(negedge clk);
    idle_all();
    rst       = r;
    din[inst] = d;
    vin[inst] = v;
    ain[inst] = a;
    cin[inst] = c;
  endtask

  task automatic expect_val(input int inst, input int kind, input logic [15:0] val);
    exp_t e;
    e.inst = inst;
    e.kind = kind;
    e.due  = cyc + ((kind == 0) ? 3 : 4);
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [63:0] D_SEQ  = 64'h0807_0605_0403_0201;  // 1..8, sum 36
  localparam logic [63:0] D_FF   = 64'hFFFF_FFFF_FFFF_FFFF;  // 2040 / -8
  localparam logic [63:0] D_ONES = 64'h0101_0101_0101_0101;  // 8
  localparam logic [63:0] D_100  = 64'h0000_0000_0000_0064;  // 100

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset out_sum", osum[i], 16'h0);
      chk("reset out_valid", {15'b0, oval[i]}, 16'h0);
      chk("reset acc_sum", asum[i], 16'h0);
      chk("reset acc_valid", {15'b0, aval[i]}, 16'h0);
    end
    rst = 1'b0;
    idle(2);

    // Single pulse of 1..8, then out_sum must hold with out_valid low.
    drive(0, D_SEQ, 1'b1, 1'b0, 1'b0); expect_val(0, 0, 16'd36);
    idle(6);
    chk("hold out_sum", osum[0], 16'd36);
    chk("hold out_valid", {15'b0, oval[0]}, 16'h0);

    // All-ones operands: unsigned and signed, signed one tagged to check sign extension.
    drive(0, D_FF, 1'b1, 1'b0, 1'b0); expect_val(0, 0, 16'h07F8);
    drive(1, D_FF, 1'b1, 1'b1, 1'b0); expect_val(1, 0, 16'h07F8); expect_val(1, 1, 16'hFFF8);
    idle(6);

    // Back-to-back with one gap after the second sample.
    drive(0, D_SEQ,  1'b1, 1'b0, 1'b0); expect_val(0, 0, 16'd36);
    drive(0, 64'h0,  1'b1, 1'b0, 1'b0); expect_val(0, 0, 16'd0);
    idle(1);
    drive(0, D_FF,   1'b1, 1'b0, 1'b0); expect_val(0, 0, 16'd2040);
    drive(0, D_ONES, 1'b1, 1'b0, 1'b0); expect_val(0, 0, 16'd8);
    idle(6);

    // 12-bit accumulator: 2040, (untagged), 4080, 2024 after wrap.
    drive(2, D_FF, 1'b1, 1'b1, 1'b0); expect_val(2, 0, 16'd2040); expect_val(2, 1, 16'd2040);
    drive(2, D_FF, 1'b1, 1'b0, 1'b0); expect_val(2, 0, 16'd2040);
    drive(2, D_FF, 1'b1, 1'b1, 1'b0); expect_val(2, 0, 16'd2040); expect_val(2, 1, 16'd4080);
    drive(2, D_FF, 1'b1, 1'b1, 1'b0); expect_val(2, 0, 16'd2040); expect_val(2, 1, 16'd2024);
    idle(6);
    chk("acc12 final", asum[2], 16'd2024);

    // Clear coinciding with a tagged completion, then a bare clear.
    drive(0, D_100, 1'b1, 1'b1, 1'b0); expect_val(0, 0, 16'd100); expect_val(0, 1, 16'd100);
    idle(6);
    drive(0, D_SEQ, 1'b1, 1'b1, 1'b0); expect_val(0, 0, 16'd36); expect_val(0, 1, 16'd36);
    idle(2);
    drive(0, 64'h0, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("clr+add acc_sum", asum[0], 16'd36);
    drive(0, 64'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("clr acc_sum", asum[0], 16'd0);
    chk("clr acc_valid", {15'b0, aval[0]}, 16'h0);
    idle(2);

    // Reset with samples in flight: none may emerge, accumulator cleared.
    drive(0, D_ONES, 1'b1, 1'b1, 1'b0); expect_val(0, 0, 16'd8); expect_val(0, 1, 16'd8);
    idle(6);
    chk("pre-reset acc_sum", asum[0], 16'd8);
    drive(0, D_SEQ,  1'b1, 1'b1, 1'b0);
    drive(0, D_FF,   1'b1, 1'b1, 1'b0);
    drive(0, D_ONES, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("post-reset out_valid", {15'b0, oval[0]}, 16'h0);
    chk("post-reset acc_sum", asum[0], 16'd0);
    idle(4);
    drive(0, D_SEQ, 1'b1, 1'b1, 1'b0); expect_val(0, 0, 16'd36); expect_val(0, 1, 16'd36);
    idle(10);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL missing inst%0d kind%0d: expected %h at cycle %0d never seen",
               sb[i].inst, sb[i].kind, sb[i].val, sb[i].due);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
